// File: rtl/dsc_pkg.sv
// Shared types for the stochastic multiplier sequencer: FSM states and width helpers.
// No logic; latency n/a; backpressure n/a.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int CYC_CNT_W = 16;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dsc_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered occupancy count.
// Latency: push visible at head one cycle later; no push-to-pop bypass.
// Backpressure: push ignored when full, pop ignored when empty.
module dsc_sync_fifo
    import dsc_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [cnt_w(DEPTH)-1:0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dsc_mul_sequencer.sv
// Buffers operand tuples and runs them one at a time through the stochastic multiplier.
// Latency: accept at edge T -> mul_en in cycle T+2; done in cycle D -> out_valid in D+1.
// Backpressure: in_ready = FIFO not full; no launch while a product awaits out_ready.
// Optional DSC_SEQ_CYCLE_CNT_EN adds o_out_cycles (saturating RUN-cycle count per product).
module dsc_mul_sequencer
    import dsc_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int OUT_WIDTH  = DATA_WIDTH * NUM_INPUTS
)(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [DATA_WIDTH-1:0]         i_in_data [NUM_INPUTS],
    output logic                          o_mul_en,
    output logic [DATA_WIDTH-1:0]         o_mul_data_in [NUM_INPUTS],
    input  logic [OUT_WIDTH-1:0]          i_mul_data_out,
    input  logic                          i_mul_done,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [OUT_WIDTH-1:0]          o_out_data,
    output logic                          o_busy,
    output logic [cnt_w(FIFO_DEPTH)-1:0]  o_fifo_count
`ifdef DSC_SEQ_CYCLE_CNT_EN
    ,
    output logic [CYC_CNT_W-1:0]          o_out_cycles
`endif
);
    localparam int TW = DATA_WIDTH * NUM_INPUTS;

    state_t          r_state;
    state_t          w_next_state;
    logic [TW-1:0]   w_in_packed;
    logic [TW-1:0]   w_head;
    logic [TW-1:0]   r_operand;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_capture;
    logic            r_out_valid;
    logic [OUT_WIDTH-1:0] r_out_data;

    always_comb begin
        w_in_packed = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_in_packed[i*DATA_WIDTH +: DATA_WIDTH] = i_in_data[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            o_mul_data_in[i] = r_operand[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign o_in_ready = !w_full;
    assign w_push     = i_in_valid && !w_full;

    dsc_sync_fifo #(
        .WIDTH (TW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_dat   (w_in_packed),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fifo_count)
    );

    // Launch waits for the output slot to drain, so capture and handshake never collide.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !r_out_valid) begin
                    w_pop        = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (i_mul_done) begin
                    w_capture    = 1'b1;
                    w_next_state = GAP;
                end
            end
            GAP:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_operand   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_operand <= w_head;
            end
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_mul_data_out;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_mul_en    = (r_state == RUN);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_busy      = !w_empty || (r_state != IDLE) || r_out_valid;

`ifdef DSC_SEQ_CYCLE_CNT_EN
    localparam logic [CYC_CNT_W-1:0] CYC_MAX = '1;

    logic [CYC_CNT_W-1:0] r_run_cnt;
    logic [CYC_CNT_W-1:0] r_out_cycles;

    // r_run_cnt counts RUN cycles before the current one; the done cycle adds one more.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_run_cnt    <= '0;
            r_out_cycles <= '0;
        end else begin
            if (w_pop) begin
                r_run_cnt <= '0;
            end else if (r_state == RUN && r_run_cnt != CYC_MAX) begin
                r_run_cnt <= r_run_cnt + CYC_CNT_W'(1);
            end
            if (w_capture) begin
                r_out_cycles <= (r_run_cnt == CYC_MAX) ? CYC_MAX : r_run_cnt + CYC_CNT_W'(1);
            end
        end
    end

    assign o_out_cycles = r_out_cycles;
`endif

endmodule
